// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF fetches and MEM accesses onto one shared bus with
// MEM priority, one outstanding transaction, flush-drop and ack timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_ce,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_inst,
  input  logic          mem_ce,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [3:0]    mem_sel,
  output logic [DW-1:0] mem_rdata,
  input  logic          flush,
  output logic          bus_ce,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_sel,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          stall_req_if,
  output logic          stall_req_mem,
  output logic          bus_err
);
  localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  typedef enum logic [2:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DONE, MEM_DONE, IF_DROP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic busy, tmo, grant_mem, grant_if;
  always_comb begin
    busy = (state == IF_BUSY) || (state == MEM_BUSY) || (state == IF_DROP);
    tmo = busy && !bus_ack && (cnt == CW'(TIMEOUT - 1));
    grant_mem = (state == IDLE) && mem_ce;
    grant_if = (state == IDLE) && !mem_ce && if_ce && !flush;
    state_nx = state;
    case (state)
      IDLE:     state_nx = grant_mem ? MEM_BUSY : grant_if ? IF_BUSY : IDLE;
      IF_BUSY:  state_nx = bus_ack ? (flush ? IDLE : IF_DONE) : tmo ? IDLE : flush ? IF_DROP : IF_BUSY;
      MEM_BUSY: state_nx = bus_ack ? MEM_DONE : tmo ? IDLE : MEM_BUSY;
      IF_DROP:  state_nx = (bus_ack || tmo) ? IDLE : IF_DROP;
      default:  state_nx = IDLE;
    endcase
  end
  assign stall_req_if = if_ce && (state != IF_DONE) && (state != IF_DROP);
  assign stall_req_mem = mem_ce && (state != MEM_DONE);
  // counter restarts on every state change, including the IF_BUSY -> IF_DROP hop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (busy && state_nx == state) ? cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ce <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_sel <= 4'h0;
    end else if (grant_mem) begin
      bus_ce <= 1'b1;
      bus_we <= mem_we;
      bus_addr <= mem_addr;
      bus_wdata <= mem_wdata;
      bus_sel <= mem_sel;
    end else if (grant_if) begin
      bus_ce <= 1'b1;
      bus_we <= 1'b0;
      bus_addr <= if_addr;
      bus_wdata <= '0;
      bus_sel <= 4'hF;
    end else if (busy && (bus_ack || tmo)) begin
      bus_ce <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_inst <= '0;
      mem_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      if_inst <= (state == IF_BUSY && bus_ack && !flush) ? bus_rdata : if_inst;
      mem_rdata <= (state == MEM_BUSY && bus_ack && !bus_we) ? bus_rdata : mem_rdata;
      bus_err <= tmo;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter grants, latency, flush, timeout and reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic if_ce, mem_ce, mem_we, flush, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0] mem_sel;
  logic [31:0] if_inst, mem_rdata, bus_addr, bus_wdata;
  logic bus_ce, bus_we, stall_req_if, stall_req_mem, bus_err;
  logic [3:0] bus_sel;
  int n_chk = 0;
  int n_fail = 0;
  int errs, drops;

  mem_arbiter #(.TIMEOUT(16), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .flush(flush),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    {if_ce, mem_ce, mem_we, flush, bus_ack} = '0;
    {if_addr, mem_addr, mem_wdata, bus_rdata} = '0;
    mem_sel = 4'h0;
    #1;
    check("rst_bus_ce", 32'(bus_ce), 0);
    check("rst_bus_sel", 32'(bus_sel), 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_bus_err", 32'(bus_err), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    // IF fetch, ack one cycle after grant
    if_ce = 1'b1;
    if_addr = 32'h100;
    #1;
    check("if_stall_idle", 32'(stall_req_if), 1);
    step();
    check("if_bus_ce", 32'(bus_ce), 1);
    check("if_bus_addr", bus_addr, 32'h100);
    check("if_bus_we", 32'(bus_we), 0);
    check("if_bus_sel", 32'(bus_sel), 32'hF);
    check("if_stall_busy", 32'(stall_req_if), 1);
    step();
    bus_ack = 1'b1;
    bus_rdata = 32'h24020005;
    #1;
    check("if_stall_ack", 32'(stall_req_if), 1);
    step();
    bus_ack = 1'b0;
    #1;
    check("if_inst", if_inst, 32'h24020005);
    check("if_stall_done", 32'(stall_req_if), 0);
    check("if_bus_ce_drop", 32'(bus_ce), 0);
    step();
    check("if_stall_after", 32'(stall_req_if), 1);
    if_ce = 1'b0;
    // simultaneous: MEM write wins, IF follows
    step();
    if_ce = 1'b1;
    if_addr = 32'h104;
    mem_ce = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h200;
    mem_wdata = 32'hDEADBEEF;
    mem_sel = 4'hF;
    step();
    check("sim_bus_we", 32'(bus_we), 1);
    check("sim_bus_addr", bus_addr, 32'h200);
    check("sim_bus_wdata", bus_wdata, 32'hDEADBEEF);
    check("sim_stall_if", 32'(stall_req_if), 1);
    check("sim_stall_mem", 32'(stall_req_mem), 1);
    bus_ack = 1'b1;
    bus_rdata = 32'h55555555;
    step();
    bus_ack = 1'b0;
    #1;
    check("sim_stall_mem_done", 32'(stall_req_mem), 0);
    check("sim_stall_if_done", 32'(stall_req_if), 1);
    check("sim_wr_no_rdata", mem_rdata, 0);
    mem_ce = 1'b0;
    step();
    check("sim_no_grant_done", 32'(bus_ce), 0);
    step();
    check("sim_if_bus_ce", 32'(bus_ce), 1);
    check("sim_if_bus_addr", bus_addr, 32'h104);
    check("sim_if_bus_we", 32'(bus_we), 0);
    bus_ack = 1'b1;
    bus_rdata = 32'h11111111;
    step();
    bus_ack = 1'b0;
    if_ce = 1'b0;
    #1;
    check("sim_if_inst", if_inst, 32'h11111111);
    step();
    // MEM read with partial byte enables
    mem_ce = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h300;
    mem_sel = 4'h3;
    step();
    check("rd_bus_sel", 32'(bus_sel), 32'h3);
    check("rd_bus_we", 32'(bus_we), 0);
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    mem_ce = 1'b0;
    #1;
    check("rd_mem_rdata", mem_rdata, 32'hCAFEF00D);
    step();
    // flush during IF_BUSY drops the returning data
    if_ce = 1'b1;
    if_addr = 32'h108;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("drop_stall_if", 32'(stall_req_if), 0);
    check("drop_bus_ce", 32'(bus_ce), 1);
    if_ce = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h12345678;
    step();
    bus_ack = 1'b0;
    #1;
    check("drop_if_inst", if_inst, 32'h11111111);
    check("drop_bus_ce_idle", 32'(bus_ce), 0);
    // stray ack in IDLE
    bus_ack = 1'b1;
    bus_rdata = 32'h99999999;
    step();
    bus_ack = 1'b0;
    #1;
    check("idle_ack_if_inst", if_inst, 32'h11111111);
    check("idle_ack_mem_rdata", mem_rdata, 32'hCAFEF00D);
    check("idle_ack_bus_ce", 32'(bus_ce), 0);
    // timeout on IF, then normal regrant
    if_ce = 1'b1;
    if_addr = 32'h10C;
    step();
    errs = 0;
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      errs += int'(bus_err);
      drops += int'(!bus_ce);
      step();
    end
    check("tmo_no_early_err", 32'(errs), 0);
    check("tmo_ce_held", 32'(drops), 0);
    check("tmo_bus_err", 32'(bus_err), 1);
    check("tmo_bus_ce", 32'(bus_ce), 0);
    check("tmo_if_inst", if_inst, 32'h11111111);
    step();
    check("tmo_err_single", 32'(bus_err), 0);
    check("tmo_regrant_ce", 32'(bus_ce), 1);
    check("tmo_regrant_addr", bus_addr, 32'h10C);
    bus_ack = 1'b1;
    bus_rdata = 32'h0BADCAFE;
    step();
    bus_ack = 1'b0;
    if_ce = 1'b0;
    #1;
    check("tmo_regrant_inst", if_inst, 32'h0BADCAFE);
    step();
    // ack on the last counter value is a success
    mem_ce = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h500;
    mem_sel = 4'hF;
    step();
    repeat (15) step();
    bus_ack = 1'b1;
    bus_rdata = 32'h5A5A5A5A;
    step();
    bus_ack = 1'b0;
    #1;
    check("edge_no_err", 32'(bus_err), 0);
    check("edge_mem_rdata", mem_rdata, 32'h5A5A5A5A);
    check("edge_stall_mem", 32'(stall_req_mem), 0);
    mem_ce = 1'b0;
    step();
    check("edge_no_late_err", 32'(bus_err), 0);
    // reset in the middle of MEM_BUSY
    mem_ce = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h400;
    mem_wdata = 32'h1;
    step();
    check("rst_mid_bus_ce", 32'(bus_ce), 1);
    mem_ce = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_bus_ce0", 32'(bus_ce), 0);
    check("rst_mid_bus_we", 32'(bus_we), 0);
    check("rst_mid_bus_addr", bus_addr, 0);
    check("rst_mid_bus_wdata", bus_wdata, 0);
    check("rst_mid_bus_sel", 32'(bus_sel), 0);
    check("rst_mid_if_inst", if_inst, 0);
    check("rst_mid_mem_rdata", mem_rdata, 0);
    check("rst_mid_bus_err", 32'(bus_err), 0);
    step();
    rst_n = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'h77777777;
    step();
    bus_ack = 1'b0;
    #1;
    check("late_ack_mem_rdata", mem_rdata, 0);
    check("late_ack_if_inst", if_inst, 0);
    check("late_ack_bus_ce", 32'(bus_ce), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
